// File: rtl/conv_puncture_serializer.sv
// Puncture/serializer stage behind the rate-1/2 K=7 convolutional encoder.
// Takes coded (A,B) pairs, keeps the bits selected by the active puncture
// pattern (1/2, 2/3, 3/4) and emits them one per beat, A before B.
//
// Handshake rule (both sides): a transfer happens on a rising clkON edge
// where valid and ready are both high. A valid source holds its data stable
// until that edge, and valid never depends on ready.
module conv_puncture_serializer #(
    parameter int BITCNT_W = 16
) (
    input  logic                clkON,
    input  logic                reset,
    input  logic [1:0]          rate_sel,
    input  logic                flush,
    input  logic                in_A,
    input  logic                in_B,
    input  logic                inp_valid_i,
    output logic                inp_ready_o,
    output logic                out_bit,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [BITCNT_W-1:0] bit_count
);

    // Pair register, pending flags, position in the puncture period, and
    // the rate currently in use for this period.
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                pend_a_q, pend_a_d;
    logic                pend_b_q, pend_b_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          rate_q, rate_d;
    logic [BITCNT_W-1:0] cnt_q, cnt_d;

    logic       fire;
    logic       accept;
    logic [1:0] eff_rate;
    logic [1:0] last_phase;
    logic       keep_a;
    logic       keep_b;

    // Output side is a pure function of the registers. A new pair may enter
    // when nothing is pending, or when the single remaining bit leaves now.
    always_comb begin
        out_valid_o = pend_a_q | pend_b_q;
        out_bit     = pend_a_q ? a_q : (pend_b_q ? b_q : 1'b0);
        inp_ready_o = ~flush & (~out_valid_o | (out_ready_i & (pend_a_q ^ pend_b_q)));
        bit_count   = cnt_q;
    end

    // Rate for the pair being accepted: a new period picks up rate_sel,
    // a period in progress keeps the rate it started with. The period length
    // and per-phase keep mask follow; reserved rate 11 acts as 1/2.
    always_comb begin
        fire     = out_valid_o & out_ready_i;
        accept   = inp_valid_i & inp_ready_o;
        eff_rate = (phase_q == 2'd0) ? rate_sel : rate_q;
        case (eff_rate)
            2'b01:   last_phase = 2'd1;
            2'b10:   last_phase = 2'd2;
            default: last_phase = 2'd0;
        endcase
        case (phase_q)
            2'd1:    begin keep_a = 1'b1; keep_b = 1'b0; end
            2'd2:    begin keep_a = 1'b0; keep_b = 1'b1; end
            default: begin keep_a = 1'b1; keep_b = 1'b1; end
        endcase
    end

    // Next-state: flush wins over fire/accept; fire retires A first, then B;
    // accept reloads the pair and advances the phase.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        phase_d  = phase_q;
        rate_d   = rate_q;
        cnt_d    = cnt_q;
        if (flush) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
            phase_d  = 2'd0;
            cnt_d    = '0;
            rate_d   = rate_sel;
        end else begin
            if (fire) begin
                if (pend_a_q) pend_a_d = 1'b0;
                else          pend_b_d = 1'b0;
                cnt_d = cnt_q + 1'b1;
            end
            if (accept) begin
                a_d      = in_A;
                b_d      = in_B;
                pend_a_d = keep_a;
                pend_b_d = keep_b;
                rate_d   = eff_rate;
                phase_d  = (phase_q == last_phase) ? 2'd0 : phase_q + 2'd1;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clkON) begin
        if (reset) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            phase_q  <= 2'd0;
            rate_q   <= 2'b00;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            phase_q  <= phase_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_conv_puncture_serializer.sv
// Bench for conv_puncture_serializer: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based model of kept bits.
module tb_conv_puncture_serializer;

    localparam int W = 1;

    logic        clkON = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rate_sel = 2'b00;
    logic        flush = 1'b0;
    logic        in_A = 1'b0;
    logic        in_B = 1'b0;
    logic        inp_valid_i = 1'b0;
    logic        inp_ready_o;
    logic        out_bit;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] bit_count;

    conv_puncture_serializer #(.BITCNT_W(16)) dut (
        .clkON(clkON), .reset(reset), .rate_sel(rate_sel), .flush(flush),
        .in_A(in_A), .in_B(in_B), .inp_valid_i(inp_valid_i),
        .inp_ready_o(inp_ready_o), .out_bit(out_bit), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .bit_count(bit_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clkON = ~clkON;

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];     // kept bits awaiting transmission, in order
    logic [W-1:0] out_log[$];   // bits seen leaving, for directed sequences
    int           m_phase = 0;
    int           m_rate  = 0;  // 0: 1/2, 1: 2/3, 2: 3/4
    logic [15:0]  m_count = '0;
    logic         last_acc = 1'b0;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven (just after negedge).
    // Compare outputs against the model, then advance the model as the
    // upcoming posedge will.
    task automatic step();
        logic m_valid, m_ready, m_bit;
        int   period;
        #1;
        m_valid = (exp_q.size() > 0);
        m_bit   = m_valid ? exp_q[0] : 1'b0;
        m_ready = !flush && (exp_q.size() == 0 || (out_ready_i && exp_q.size() == 1));
        check("out_valid", out_valid_o, m_valid);
        check("out_bit", out_bit, m_bit);
        check("inp_ready", inp_ready_o, m_ready);
        check("bit_count", bit_count, m_count);
        last_acc = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_phase = 0; m_rate = 0; m_count = '0;
        end else if (flush) begin
            exp_q.delete();
            m_phase = 0; m_count = '0;
            m_rate = (rate_sel == 2'b11) ? 0 : int'(rate_sel);
        end else begin
            if (m_valid && out_ready_i) begin
                out_log.push_back(exp_q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (inp_valid_i && m_ready) begin
                last_acc = 1'b1;
                if (m_phase == 0) m_rate = (rate_sel == 2'b11) ? 0 : int'(rate_sel);
                period = m_rate + 1;
                if (m_phase != 2) exp_q.push_back(in_A);
                if (m_phase != 1) exp_q.push_back(in_B);
                m_phase = (m_phase + 1) % period;
            end
        end
        @(negedge clkON);
    endtask

    // ---------------- drivers ----------------
    task automatic send_pair(input logic a, input logic b);
        int n = 0;
        in_A = a; in_B = b; inp_valid_i = 1'b1;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) check("accept_timeout", 0, 1);
        inp_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        inp_valid_i = 1'b0;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 0, 1);
        step();
    endtask

    task automatic start_test(input logic [1:0] r);
        rate_sel = r; flush = 1'b1;
        step();
        flush = 1'b0;
        out_log.delete();
    endtask

    // Compare logged output against bits listed MSB-first in exp_bits.
    task automatic check_log(input string tag, input logic [15:0] exp_bits, input int n);
        check({tag, "_len"}, out_log.size(), n);
        for (int i = 0; i < n && i < out_log.size(); i++)
            check(tag, out_log[i], exp_bits[n-1-i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clkON);
        @(negedge clkON);
        #1;
        check("rst_valid", out_valid_o, 0);
        check("rst_bit", out_bit, 0);
        check("rst_ready", inp_ready_o, 1);
        check("rst_count", bit_count, 0);
        step();
        reset = 1'b0;

        // rate 1/2
        start_test(2'b00); out_ready_i = 1'b1;
        send_pair(1, 0); send_pair(0, 1); send_pair(1, 1); drain();
        check_log("t1", 16'b100111, 6);
        check("t1_count", bit_count, 6);

        // rate 2/3
        start_test(2'b01);
        send_pair(1, 0); send_pair(1, 1); send_pair(0, 1); send_pair(0, 0); drain();
        check_log("t2", 16'b101010, 6);
        check("t2_count", bit_count, 6);

        // rate 3/4
        start_test(2'b10);
        send_pair(1, 1); send_pair(0, 1); send_pair(1, 0);
        send_pair(1, 0); send_pair(0, 1); send_pair(1, 1); drain();
        check_log("t3", 16'b11001001, 8);
        check("t3_count", bit_count, 8);

        // backpressure: output held, input stalled
        start_test(2'b00); out_ready_i = 1'b0;
        send_pair(1, 0);
        in_A = 0; in_B = 1; inp_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_bit", out_bit, 1);
            check("bp_hold_valid", out_valid_o, 1);
        end
        out_ready_i = 1'b1;
        send_pair(0, 1); drain();
        check_log("t4", 16'b1001, 4);

        // rate change mid-period, then reserved rate
        start_test(2'b10);
        send_pair(1, 0);
        rate_sel = 2'b00;
        send_pair(1, 0); send_pair(0, 1); send_pair(1, 1); send_pair(0, 1); drain();
        check_log("t5", 16'b10111101, 8);
        start_test(2'b11);
        send_pair(1, 0); send_pair(0, 1); drain();
        check_log("t5r", 16'b1001, 4);

        // flush while B pending and a pair offered
        start_test(2'b00);
        send_pair(1, 1);
        step();                       // A leaves, B still pending
        check("fl_pre_valid", out_valid_o, 1);
        flush = 1'b1; in_A = 0; in_B = 0; inp_valid_i = 1'b1;
        step();
        flush = 1'b0; inp_valid_i = 1'b0;
        #1;
        check("fl_valid", out_valid_o, 0);
        check("fl_count", bit_count, 0);
        step();

        // reset mid-stream
        out_ready_i = 1'b0;
        send_pair(1, 1);
        reset = 1'b1; step(); reset = 1'b0;
        #1;
        check("mrst_valid", out_valid_o, 0);
        check("mrst_ready", inp_ready_o, 1);
        check("mrst_count", bit_count, 0);
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rate_sel    = 2'($urandom_range(0, 3));
            in_A        = 1'($urandom_range(0, 1));
            in_B        = 1'($urandom_range(0, 1));
            inp_valid_i = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 63) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; out_ready_i = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
